pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_W, 5, program counter and target address width in bits.
REQ-002 Parameter PROG_LEN, 6, number of valid instructions; legal addresses are 0..PROG_LEN-1; PROG_LEN SHALL be in 2..2**ADDR_W.
REQ-003 Parameter OFS_W, 4, width of the signed branch offset.
REQ-004 Parameter STACK_DEPTH, 4, number of return-stack entries; STACK_DEPTH SHALL be at least 1.
REQ-005 clk  input  1  clock; all state SHALL update on the rising edge only.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 step  input  1  advance enable; one action per cycle while high.
REQ-008 halt  input  1  halt request, qualified by step.
REQ-009 ret  input  1  return from subroutine, qualified by step.
REQ-010 call  input  1  subroutine call to target, qualified by step.
REQ-011 jump  input  1  absolute jump to target, qualified by step.
REQ-012 branch_taken  input  1  relative branch, qualified by step.
REQ-013 target  input  ADDR_W  absolute address for jump and call.
REQ-014 branch_ofs  input  OFS_W  two's-complement offset, relative to the current pc.
REQ-015 pc_address  output  ADDR_W  current instruction address, driven from a register.
REQ-016 halted  output  1  sticky halt flag.
REQ-017 err  output  1  sticky fault flag.
REQ-018 stack_empty, stack_full  output  1 each  return-stack status, driven from registers.

Function
REQ-019 When step=0 or halted=1, pc_address, the stack contents and all flags SHALL hold, except as stated in REQ-029.
REQ-020 When step=1 and halted=0, exactly one action SHALL execute, chosen by fixed priority: halt > ret > call > jump > branch_taken > increment.
REQ-021 Increment: pc_next = pc+1; when pc = PROG_LEN-1, pc_next SHALL wrap to 0.
REQ-022 halt: halted <= 1 and pc holds.
REQ-023 jump: pc <= target when target < PROG_LEN; otherwise pc <= 0 and err <= 1.
REQ-024 branch_taken: compute sum = pc + sign-extended branch_ofs in ADDR_W+2 signed bits, with no wrap.
REQ-025 branch_taken: pc <= sum when 0 <= sum < PROG_LEN; otherwise pc <= 0 and err <= 1.
REQ-026 call, stack not full: push the increment value of REQ-021, then apply the jump rule of REQ-023 to target.
REQ-027 call, stack full: no push; pc holds; err <= 1; halted <= 1.
REQ-028 ret, stack not empty: pop and pc <= the popped value. ret, stack empty: pc holds; err <= 1; halted <= 1.
REQ-029 stack_full and stack_empty SHALL reflect the occupancy after the action, visible in the cycle after the action.
REQ-030 Every action SHALL have one-cycle latency: the new pc_address appears on the clock edge that samples step.
REQ-031 err and halted SHALL be cleared only by reset.
REQ-032 Lower-priority requests asserted in the same cycle as a higher-priority one SHALL be ignored and SHALL NOT be queued.

Reset
REQ-033 While reset=1 the following SHALL be forced on each clock edge: pc_address=0, stack pointer=0, stack_empty=1, stack_full=0, halted=0, err=0.
REQ-034 reset SHALL override step and all other requests in the same cycle, including mid-call and mid-ret.
REQ-035 Stack entry contents need not be reset.

Structure
REQ-036 The action encoding (HALT, RET, CALL, JUMP, BRANCH, INC) and the priority-select function SHALL reside in shared package pc_seq_pkg.
REQ-037 The return stack SHALL be a separate sub-module, pc_return_stack, parametrised by ADDR_W and STACK_DEPTH.
REQ-038 pc_return_stack SHALL have push, pop, wdata, rdata, empty and full ports, with synchronous pointer update.
REQ-039 No combinational path SHALL exist from any input to any output.

Verification
REQ-040 Defaults, reset, then step high for 7 cycles -> pc_address 1,2,3,4,5,0,1.
REQ-041 pc=2, step+jump, target=4 -> pc=4, err=0; step+jump, target=7 -> pc=0, err=1.
REQ-042 pc=3, step+branch_taken, ofs=-2 -> pc=1; then step+branch_taken, ofs=-3 -> pc=0, err=1.
REQ-043 STACK_DEPTH=2: call to 4 from pc=1, then call to 2 -> stack_full=1; ret -> pc=5; ret -> pc=2, stack_empty=1; a further ret -> pc holds, err=1, halted=1.
REQ-044 Same cycle: step with halt, call and jump all asserted -> halted=1, pc unchanged, no push; further step cycles leave pc frozen.
REQ-045 reset asserted in the same cycle as step+call with the stack partly filled -> next cycle pc=0, stack_empty=1, err=0, halted=0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: action encoding and fixed-priority action select for pc_sequencer
package pc_seq_pkg;
   typedef enum logic [2:0] {HALT, RET, CALL, JUMP, BRANCH, INC} action_t;
   function automatic action_t sel_action(input logic halt, input logic ret, input logic call,
                                          input logic jump, input logic branch_taken);
      return halt ? HALT : ret ? RET : call ? CALL : jump ? JUMP : branch_taken ? BRANCH : INC;
   endfunction
endpackage

// File: rtl/pc_return_stack.sv
// pc_return_stack: LIFO of return addresses with registered empty/full status
module pc_return_stack #(
   parameter int ADDR_W = 5,
   parameter int STACK_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] wdata,
   output logic [ADDR_W-1:0] rdata,
   output logic              empty,
   output logic              full
);
   localparam int PW = $clog2(STACK_DEPTH + 1);
   localparam int IW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
   logic [ADDR_W-1:0] mem [1 << IW];
   logic [PW-1:0] sp, sp_n;
   logic do_push, do_pop;
   assign do_push = push & ~full;
   assign do_pop = pop & ~empty;
   assign sp_n = sp + PW'(do_push) - PW'(do_pop);
   assign rdata = mem[IW'(empty ? '0 : sp - 1'b1)];
   // pointer and status flags track the occupancy after this cycle's push/pop
   always_ff @(posedge clk) begin
      if (reset) begin
         sp <= '0;
         empty <= 1'b1;
         full <= 1'b0;
      end else begin
         sp <= sp_n;
         empty <= sp_n == '0;
         full <= sp_n == PW'(STACK_DEPTH);
      end
   end
   // entry storage is left unreset; only the pointer defines validity
   always_ff @(posedge clk) begin
      if (do_push) mem[IW'(sp)] <= wdata;
   end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with jump, relative branch, call/return stack and sticky halt/err
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int PROG_LEN = 6,
   parameter int OFS_W = 4,
   parameter int STACK_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              step,
   input  logic              halt,
   input  logic              ret,
   input  logic              call,
   input  logic              jump,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] target,
   input  logic [OFS_W-1:0]  branch_ofs,
   output logic [ADDR_W-1:0] pc_address,
   output logic              halted,
   output logic              err,
   output logic              stack_empty,
   output logic              stack_full
);
   localparam int SW = ADDR_W + 2;
   action_t act;
   logic [ADDR_W-1:0] pc_inc, pc_n, rdata;
   logic signed [SW-1:0] sum;
   logic jump_ok, br_ok, push, pop, halted_n, err_n;
   assign act = sel_action(halt, ret, call, jump, branch_taken);
   assign pc_inc = pc_address == ADDR_W'(PROG_LEN - 1) ? '0 : pc_address + 1'b1;
   assign jump_ok = {1'b0, target} < (ADDR_W + 1)'(PROG_LEN);
   assign sum = $signed({2'b00, pc_address}) + SW'($signed(branch_ofs));
   assign br_ok = !sum[SW-1] && sum < SW'(PROG_LEN);
   pc_return_stack #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) u_stack (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .wdata(pc_inc),
      .rdata(rdata), .empty(stack_empty), .full(stack_full)
   );
   // select exactly one action per enabled step; out-of-range targets fall back to 0 with err
   always_comb begin
      pc_n = pc_address;
      halted_n = halted;
      err_n = err;
      push = 1'b0;
      pop = 1'b0;
      if (step && !halted) begin
         case (act)
            HALT: halted_n = 1'b1;
            RET: begin
               pop = !stack_empty;
               pc_n = stack_empty ? pc_address : rdata;
               halted_n = halted | stack_empty;
               err_n = err | stack_empty;
            end
            CALL: begin
               push = !stack_full;
               pc_n = stack_full ? pc_address : jump_ok ? target : '0;
               halted_n = halted | stack_full;
               err_n = err | stack_full | !jump_ok;
            end
            JUMP: begin
               pc_n = jump_ok ? target : '0;
               err_n = err | !jump_ok;
            end
            BRANCH: begin
               pc_n = br_ok ? sum[ADDR_W-1:0] : '0;
               err_n = err | !br_ok;
            end
            default: pc_n = pc_inc;
         endcase
      end
   end
   // pc and sticky flags register the selected action; reset wins over everything
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_address <= '0;
         halted <= 1'b0;
         err <= 1'b0;
      end else begin
         pc_address <= pc_n;
         halted <= halted_n;
         err <= err_n;
      end
   end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and random checks of pc_sequencer against a queue-based model
module tb_pc_sequencer;
   localparam int ADDR_W = 5;
   localparam int PROG_LEN = 6;
   localparam int OFS_W = 4;
   localparam int DEPTH = 2;
   logic clk = 1'b0;
   logic reset = 1'b0, step = 1'b0, halt = 1'b0, ret = 1'b0, call = 1'b0, jump = 1'b0, branch_taken = 1'b0;
   logic [ADDR_W-1:0] target = '0;
   logic [OFS_W-1:0] branch_ofs = '0;
   logic [ADDR_W-1:0] pc_address;
   logic halted, err, stack_empty, stack_full;
   int errors = 0, checks = 0;
   int m_pc = 0;
   bit m_halted = 0, m_err = 0;
   int m_stk[$];

   pc_sequencer #(.ADDR_W(ADDR_W), .PROG_LEN(PROG_LEN), .OFS_W(OFS_W), .STACK_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .step(step), .halt(halt), .ret(ret), .call(call), .jump(jump),
      .branch_taken(branch_taken), .target(target), .branch_ofs(branch_ofs),
      .pc_address(pc_address), .halted(halted), .err(err),
      .stack_empty(stack_empty), .stack_full(stack_full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic model();
      int s;
      if (reset) begin
         m_pc = 0; m_halted = 0; m_err = 0; m_stk.delete();
      end else if (step && !m_halted) begin
         if (halt) m_halted = 1;
         else if (ret) begin
            if (m_stk.size() == 0) begin m_err = 1; m_halted = 1; end
            else m_pc = m_stk.pop_back();
         end else if (call) begin
            if (m_stk.size() == DEPTH) begin m_err = 1; m_halted = 1; end
            else begin
               m_stk.push_back((m_pc + 1) % PROG_LEN);
               if (int'(target) < PROG_LEN) m_pc = int'(target); else begin m_pc = 0; m_err = 1; end
            end
         end else if (jump) begin
            if (int'(target) < PROG_LEN) m_pc = int'(target); else begin m_pc = 0; m_err = 1; end
         end else if (branch_taken) begin
            s = m_pc + int'($signed(branch_ofs));
            if (s >= 0 && s < PROG_LEN) m_pc = s; else begin m_pc = 0; m_err = 1; end
         end else m_pc = (m_pc + 1) % PROG_LEN;
      end
   endtask

   task automatic drive(input logic r, input logic s, input logic h, input logic rt, input logic c,
                        input logic j, input logic b, input logic [ADDR_W-1:0] t, input logic [OFS_W-1:0] o);
      reset = r; step = s; halt = h; ret = rt; call = c; jump = j; branch_taken = b; target = t; branch_ofs = o;
      @(posedge clk);
      model();
      #1;
      chk("pc", 32'(pc_address), 32'(m_pc));
      chk("halted", 32'(halted), 32'(m_halted));
      chk("err", 32'(err), 32'(m_err));
      chk("empty", 32'(stack_empty), 32'(m_stk.size() == 0));
      chk("full", 32'(stack_full), 32'(m_stk.size() == DEPTH));
   endtask

   task automatic do_reset(); drive(1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic do_step(); drive(0, 1, 0, 0, 0, 0, 0, 0, 0); endtask

   initial begin
      int exp_seq[7] = '{1, 2, 3, 4, 5, 0, 1};
      #2;
      do_reset();
      chk("rst_pc", 32'(pc_address), 0);
      chk("rst_empty", 32'(stack_empty), 1);
      // increment with wrap
      for (int i = 0; i < 7; i++) begin
         do_step();
         chk("inc_seq", 32'(pc_address), 32'(exp_seq[i]));
      end
      // step low holds
      drive(0, 0, 0, 0, 0, 1, 0, 3, 0);
      chk("hold", 32'(pc_address), 1);
      // jump valid and out of range
      do_reset(); do_step(); do_step();
      drive(0, 1, 0, 0, 0, 1, 0, 4, 0);
      chk("jump_ok", 32'(pc_address), 4);
      chk("jump_ok_err", 32'(err), 0);
      drive(0, 1, 0, 0, 0, 1, 0, 7, 0);
      chk("jump_bad", 32'(pc_address), 0);
      chk("jump_bad_err", 32'(err), 1);
      // relative branch backwards and below zero
      do_reset(); do_step(); do_step(); do_step();
      drive(0, 1, 0, 0, 0, 0, 1, 0, 4'hE);
      chk("br_back", 32'(pc_address), 1);
      drive(0, 1, 0, 0, 0, 0, 1, 0, 4'hD);
      chk("br_under", 32'(pc_address), 0);
      chk("br_under_err", 32'(err), 1);
      // nested calls, returns and return underflow
      do_reset(); do_step();
      drive(0, 1, 0, 0, 1, 0, 0, 4, 0);
      chk("call1", 32'(pc_address), 4);
      drive(0, 1, 0, 0, 1, 0, 0, 2, 0);
      chk("call2", 32'(pc_address), 2);
      chk("call2_full", 32'(stack_full), 1);
      drive(0, 1, 0, 1, 0, 0, 0, 0, 0);
      chk("ret1", 32'(pc_address), 5);
      drive(0, 1, 0, 1, 0, 0, 0, 0, 0);
      chk("ret2", 32'(pc_address), 2);
      chk("ret2_empty", 32'(stack_empty), 1);
      drive(0, 1, 0, 1, 0, 0, 0, 0, 0);
      chk("ret_under_pc", 32'(pc_address), 2);
      chk("ret_under_err", 32'(err), 1);
      chk("ret_under_halt", 32'(halted), 1);
      // call on full stack
      do_reset();
      drive(0, 1, 0, 0, 1, 0, 0, 3, 0);
      drive(0, 1, 0, 0, 1, 0, 0, 1, 0);
      drive(0, 1, 0, 0, 1, 0, 0, 5, 0);
      chk("call_full_pc", 32'(pc_address), 1);
      chk("call_full_halt", 32'(halted), 1);
      // halt beats call and jump, then freezes
      do_reset(); do_step();
      drive(0, 1, 1, 0, 1, 1, 0, 3, 0);
      chk("halt_pc", 32'(pc_address), 1);
      chk("halt_flag", 32'(halted), 1);
      chk("halt_nopush", 32'(stack_empty), 1);
      do_step(); do_step();
      chk("halt_frozen", 32'(pc_address), 1);
      // reset overrides step+call mid-stack
      do_reset(); do_step();
      drive(0, 1, 0, 0, 1, 0, 0, 3, 0);
      drive(1, 1, 0, 0, 1, 0, 0, 2, 0);
      chk("rst_call_pc", 32'(pc_address), 0);
      chk("rst_call_empty", 32'(stack_empty), 1);
      chk("rst_call_err", 32'(err), 0);
      chk("rst_call_halt", 32'(halted), 0);
      // random traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic r;
         r = ($urandom_range(0, 39) == 0) || (m_halted && $urandom_range(0, 3) == 0);
         drive(r, $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
               ADDR_W'($urandom_range(0, 7)), OFS_W'($urandom));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
